// File: rtl/bus_ram_responder_pkg.sv
// Shared bus widths and responder state encoding for the request/ready RAM responder.
package bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int BUS_MW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } responder_state_t;

endpackage

// File: rtl/bus_ram_responder_if.sv
// Request/ready bus between an initiator (CPU port or fabric) and a responder.
interface bus_ram_responder_if;
  import bus_pkg::*;

  logic              i_request;
  logic              i_rw;
  logic [BUS_AW-1:0] i_address;
  logic [BUS_DW-1:0] i_wdata;
  logic [BUS_MW-1:0] i_wmask;
  logic              o_ready;
  logic [BUS_DW-1:0] o_rdata;
  logic              o_error;

  modport master (
    output i_request, i_rw, i_address, i_wdata, i_wmask,
    input  o_ready, o_rdata, o_error
  );

  modport slave (
    input  i_request, i_rw, i_address, i_wdata, i_wmask,
    output o_ready, o_rdata, o_error
  );

endinterface

// File: rtl/bus_ram_responder_array.sv
// Single-port word RAM with byte enables and a registered read port.
module bus_ram_array
  import bus_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [BUS_DW-1:0]     wdata,
  input  logic [BUS_MW-1:0]     wmask,
  output logic [BUS_DW-1:0]     rdata
);

  logic [BUS_DW-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BUS_MW; b++) begin
        if (wmask[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Only the output register is cleared by reset; array contents survive it.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_ram_responder.sv
// Bus responder serving word accesses from on-chip RAM after a fixed number of wait states,
// answering out-of-window addresses with an error instead of stalling the initiator.
module bus_ram_responder
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
  parameter int          SIZE_LOG2    = 12,
  parameter int          LATENCY      = 1
) (
  input logic                i_clock,
  input logic                i_reset,
  bus_ram_responder_if.slave bus
);

  localparam int WORD_AW = SIZE_LOG2 - 2;

  responder_state_t  state;
  responder_state_t  state_next;
  logic [3:0]        wait_cnt;

  logic              rw_q;
  logic              in_range_q;
  logic [WORD_AW-1:0] word_q;
  logic [BUS_DW-1:0] wdata_q;
  logic [BUS_MW-1:0] wmask_q;
  logic              error_q;

  logic [BUS_AW-1:0] offset;
  logic              in_range;
  logic              accept;
  logic              enter_respond;
  logic              sel_rw;
  logic              sel_in_range;
  logic [WORD_AW-1:0] sel_word;
  logic              ram_re;
  logic              ram_we;
  logic [BUS_DW-1:0] ram_rdata;
  logic              unused_bits;

  assign offset      = bus.i_address - BASE_ADDRESS;
  assign in_range    = (offset[BUS_AW-1:SIZE_LOG2] == '0);
  assign unused_bits = ^offset[1:0];
  assign accept      = (state == IDLE) && bus.i_request;

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Counter reaches zero on the same edge that enters RESPOND, hence the compare with 1.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.i_request) state_next = (LATENCY == 0) ? RESPOND : WAIT;
      WAIT: begin
        if (!bus.i_request)       state_next = IDLE;
        else if (wait_cnt == 4'd1) state_next = RESPOND;
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.o_ready = (state == RESPOND);
    bus.o_error = error_q;
    bus.o_rdata = error_q ? '0 : ram_rdata;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset)              wait_cnt <= '0;
    else if (accept)          wait_cnt <= 4'(LATENCY);
    else if (state == WAIT)   wait_cnt <= wait_cnt - 4'd1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rw_q       <= 1'b0;
      in_range_q <= 1'b0;
      word_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else if (accept) begin
      rw_q       <= bus.i_rw;
      in_range_q <= in_range;
      word_q     <= offset[SIZE_LOG2-1:2];
      wdata_q    <= bus.i_wdata;
      wmask_q    <= bus.i_wmask;
    end
  end

  // With zero latency the read is launched straight from the live request in IDLE.
  assign sel_rw        = (state == IDLE) ? bus.i_rw : rw_q;
  assign sel_in_range  = (state == IDLE) ? in_range : in_range_q;
  assign sel_word      = (state == IDLE) ? offset[SIZE_LOG2-1:2] : word_q;
  assign enter_respond = (state_next == RESPOND) && (state != RESPOND);
  assign ram_re        = enter_respond && !sel_rw && sel_in_range && !i_reset;
  assign ram_we        = (state == RESPOND) && rw_q && in_range_q && !i_reset;

  always_ff @(posedge i_clock) begin
    if (i_reset)            error_q <= 1'b0;
    else if (enter_respond) error_q <= !sel_in_range;
  end

  bus_ram_array #(
    .DEPTH_LOG2 (WORD_AW)
  ) u_ram (
    .clk   (i_clock),
    .rst   (i_reset),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (sel_word),
    .wdata (wdata_q),
    .wmask (wmask_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_bus_ram_responder.sv
// Scoreboard bench: responder A with two wait states, responder B with none.
module tb_bus_ram_responder;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          LAT_A = 2;
  localparam int          LAT_B = 0;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
    int          edge_no;
  } exp_t;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q_a[$];
  exp_t q_b[$];

  bus_ram_responder_if bus_a ();
  bus_ram_responder_if bus_b ();

  bus_ram_responder #(.BASE_ADDRESS(BASE), .SIZE_LOG2(12), .LATENCY(LAT_A)) dut_a (
    .i_clock (clk),
    .i_reset (rst_a),
    .bus     (bus_a.slave)
  );

  bus_ram_responder #(.BASE_ADDRESS(BASE), .SIZE_LOG2(12), .LATENCY(LAT_B)) dut_b (
    .i_clock (clk),
    .i_reset (rst_b),
    .bus     (bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input bit sel, input logic req, input logic rw, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask);
    if (sel) begin
      bus_b.i_request = req; bus_b.i_rw = rw; bus_b.i_address = addr;
      bus_b.i_wdata = wdata; bus_b.i_wmask = mask;
    end else begin
      bus_a.i_request = req; bus_a.i_rw = rw; bus_a.i_address = addr;
      bus_a.i_wdata = wdata; bus_a.i_wmask = mask;
    end
  endtask

  task automatic push_exp(input bit sel, input logic is_read, input logic [31:0] rdata,
                          input logic err, input int edge_no);
    exp_t e;
    e.is_read = is_read; e.rdata = rdata; e.err = err; e.edge_no = edge_no;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  task automatic score(input bit sel, input logic [31:0] rdata, input logic err);
    exp_t e;
    if (sel ? (q_b.size() == 0) : (q_a.size() == 0)) begin
      check_eq(sel ? "b_spurious_ready" : "a_spurious_ready", 32'd1, 32'd0);
      return;
    end
    if (sel) e = q_b.pop_front();
    else     e = q_a.pop_front();
    check_eq(sel ? "b_ready_edge" : "a_ready_edge", 32'(cyc + 1), 32'(e.edge_no));
    check_eq(sel ? "b_error" : "a_error", 32'(err), 32'(e.err));
    if (e.is_read) check_eq(sel ? "b_rdata" : "a_rdata", rdata, e.rdata);
  endtask

  always @(negedge clk) begin
    if (bus_a.o_ready) score(1'b0, bus_a.o_rdata, bus_a.o_error);
    if (bus_b.o_ready) score(1'b1, bus_b.o_rdata, bus_b.o_error);
  end

  // Called at a negedge with the responder idle; returns at the negedge after o_ready.
  task automatic access(input bit sel, input logic rw, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        input logic [31:0] exp_rdata, input logic exp_err);
    bit done;
    push_exp(sel, !rw, exp_rdata, exp_err, cyc + 2 + (sel ? LAT_B : LAT_A));
    drive(sel, 1'b1, rw, addr, wdata, mask);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (sel ? bus_b.o_ready : bus_a.o_ready) done = 1'b1;
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    if (!done) begin
      check_eq("access_timeout", 32'd0, 32'd1);
      if (sel && q_b.size() > 0) void'(q_b.pop_front());
      if (!sel && q_a.size() > 0) void'(q_a.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic count_ready_a(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus_a.o_ready) seen++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int n_ready;
    int idx;
    int last;
    logic [31:0] vals [4];

    checks = 0;
    errors = 0;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);

    check_eq("a_reset_ready", 32'(bus_a.o_ready), 32'd0);
    check_eq("a_reset_rdata", bus_a.o_rdata, 32'h0);
    check_eq("a_reset_error", 32'(bus_a.o_error), 32'd0);
    check_eq("b_reset_ready", 32'(bus_b.o_ready), 32'd0);
    check_eq("b_reset_rdata", bus_b.o_rdata, 32'h0);
    check_eq("b_reset_error", 32'(bus_b.o_error), 32'd0);

    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    // Full write, then partial byte-masked overwrite.
    access(1'b0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    access(1'b0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    access(1'b0, 1'b1, BASE + 32'h10, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
    access(1'b0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);

    // Window edges: first word, last word, one past the end, one below the base.
    access(1'b0, 1'b1, BASE, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
    access(1'b0, 1'b1, BASE + 32'hFFC, 32'hA5A5_5A5A, 4'hF, 32'h0, 1'b0);
    access(1'b0, 1'b0, BASE + 32'hFFC, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0);
    access(1'b0, 1'b0, BASE + 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1);
    access(1'b0, 1'b1, BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    access(1'b0, 1'b0, BASE - 32'h4, 32'h0, 4'h0, 32'h0, 1'b1);
    access(1'b0, 1'b0, BASE, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);

    // Empty byte mask completes but leaves the word alone.
    access(1'b0, 1'b1, BASE + 32'h10, 32'h1234_5678, 4'h0, 32'h0, 1'b0);
    access(1'b0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);

    // Abort a write after one wait-state cycle.
    drive(1'b0, 1'b1, 1'b1, BASE + 32'h10, 32'h9999_9999, 4'hF);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    count_ready_a(8, seen);
    check_eq("abort_no_ready", 32'(seen), 32'd0);
    access(1'b0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);

    // Reset while a write sits in WAIT.
    access(1'b0, 1'b1, BASE + 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    access(1'b0, 1'b0, BASE + 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    drive(1'b0, 1'b1, 1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    rst_a = 1'b0;
    check_eq("rst_rdata_cleared", bus_a.o_rdata, 32'h0);
    check_eq("rst_error_cleared", 32'(bus_a.o_error), 32'd0);
    count_ready_a(8, seen);
    check_eq("rst_no_ready", 32'(seen), 32'd0);
    access(1'b0, 1'b0, BASE + 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);

    // Zero-latency responder: preload, then stream reads with request held high.
    for (int i = 0; i < 4; i++) begin
      vals[i] = 32'hA0B0_C0D0 + 32'(i * 32'h0101_0101);
      access(1'b1, 1'b1, BASE + 32'(4 * i), vals[i], 4'hF, 32'h0, 1'b0);
    end
    push_exp(1'b1, 1'b1, vals[0], 1'b0, cyc + 2);
    drive(1'b1, 1'b1, 1'b0, BASE, 32'h0, 4'h0);
    idx = 1;
    last = -1;
    n_ready = 0;
    for (int i = 0; i < 40 && n_ready < 4; i++) begin
      @(negedge clk);
      if (bus_b.o_ready) begin
        if (last >= 0) check_eq("stream_period", 32'(cyc - last), 32'd2);
        last = cyc;
        n_ready++;
        if (idx < 4) begin
          drive(1'b1, 1'b1, 1'b0, BASE + 32'(4 * idx), 32'h0, 4'h0);
          push_exp(1'b1, 1'b1, vals[idx], 1'b0, cyc + 3);
          idx++;
        end else begin
          drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
      end
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_eq("stream_count", 32'(n_ready), 32'd4);
    @(negedge clk);
    access(1'b1, 1'b0, BASE + 32'h2000, 32'h0, 4'h0, 32'h0, 1'b1);
    access(1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0, vals[2], 1'b0);

    repeat (4) @(negedge clk);
    check_eq("a_queue_drained", 32'(q_a.size()), 32'd0);
    check_eq("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
